// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Pipeline MEM stage with 64x32 data memory, branch/jump redirect,
//               MEM/WB register and a sticky halting exception unit.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic [31:0] M_Jtarg,
  input  logic [31:0] M_Btarg,
  input  logic        M_Zero,
  input  logic        M_Overflow,
  input  logic [31:0] M_ALUout,
  input  logic [31:0] M_busB,
  input  logic [4:0]  M_Rw,
  input  logic        M_Jump,
  input  logic        M_Branch,
  input  logic        M_MemWr,
  input  logic        M_RegWr,
  input  logic        M_MemtoReg,
  output logic        NPC_sel,
  output logic [31:0] NPC_target,
  output logic        Flush,
  output logic [31:0] W_Dout,
  output logic [31:0] W_ALUout,
  output logic [4:0]  W_Rw,
  output logic        W_RegWr,
  output logic        W_MemtoReg,
  output logic        Exc,
  output logic [1:0]  Exc_cause,
  output logic [31:0] Exc_addr
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam int c_DEPTH = 64;

  state_t      state_q, state_d;
  logic        exc_q, exc_d;
  logic [1:0]  exc_cause_q, exc_cause_d;
  logic [31:0] exc_addr_q, exc_addr_d;
  logic [31:0] w_dout_q, w_dout_d;
  logic [31:0] w_aluout_q, w_aluout_d;
  logic [4:0]  w_rw_q, w_rw_d;
  logic        w_regwr_q, w_regwr_d;
  logic        w_memtoreg_q, w_memtoreg_d;

  // Memory survives reset; only the time-zero value is defined.
  logic [31:0] mem_q [c_DEPTH] = '{default: '0};

  logic [5:0]  w_word_idx;
  logic [31:0] w_rd_data;
  logic        w_misaligned;
  logic        w_fault;
  logic        w_halted;
  logic        w_allow;
  logic        w_mem_we;

  assign w_word_idx   = M_ALUout[7:2];
  assign w_rd_data    = mem_q[w_word_idx];
  assign w_misaligned = (M_MemWr | M_MemtoReg) & (M_ALUout[1:0] != 2'b00);
  assign w_fault      = M_Overflow | w_misaligned;
  assign w_halted     = (state_q == HALT);
  assign w_allow      = ~w_fault & ~w_halted;
  assign w_mem_we     = M_MemWr & w_allow & ~Clrn;

  // Jump outranks a taken branch.
  always_comb begin
    NPC_sel    = 1'b0;
    NPC_target = 32'h0;
    if (w_allow) begin
      if (M_Jump) begin
        NPC_sel    = 1'b1;
        NPC_target = M_Jtarg;
      end else if (M_Branch & M_Zero) begin
        NPC_sel    = 1'b1;
        NPC_target = M_Btarg;
      end
    end
  end

  assign Flush = NPC_sel;

  always_comb begin
    state_d      = state_q;
    exc_d        = exc_q;
    exc_cause_d  = exc_cause_q;
    exc_addr_d   = exc_addr_q;
    w_dout_d     = w_rd_data;
    w_aluout_d   = M_ALUout;
    w_rw_d       = M_Rw;
    w_memtoreg_d = M_MemtoReg;
    w_regwr_d    = M_RegWr & w_allow;
    if (state_q == RUN && w_fault) begin
      state_d     = HALT;
      exc_d       = 1'b1;
      exc_cause_d = {w_misaligned & ~M_Overflow, M_Overflow};
      exc_addr_d  = M_ALUout;
    end
  end

  always_ff @(negedge Clk or posedge Clrn) begin
    if (Clrn) begin
      state_q      <= RUN;
      exc_q        <= 1'b0;
      exc_cause_q  <= 2'b00;
      exc_addr_q   <= 32'h0;
      w_dout_q     <= 32'h0;
      w_aluout_q   <= 32'h0;
      w_rw_q       <= 5'h0;
      w_regwr_q    <= 1'b0;
      w_memtoreg_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      exc_q        <= exc_d;
      exc_cause_q  <= exc_cause_d;
      exc_addr_q   <= exc_addr_d;
      w_dout_q     <= w_dout_d;
      w_aluout_q   <= w_aluout_d;
      w_rw_q       <= w_rw_d;
      w_regwr_q    <= w_regwr_d;
      w_memtoreg_q <= w_memtoreg_d;
    end
  end

  // Non-blocking write keeps the same-edge MEM/WB capture on the old word.
  always_ff @(negedge Clk) begin
    if (w_mem_we) begin
      mem_q[w_word_idx] <= M_busB;
    end
  end

  assign W_Dout     = w_dout_q;
  assign W_ALUout   = w_aluout_q;
  assign W_Rw       = w_rw_q;
  assign W_RegWr    = w_regwr_q;
  assign W_MemtoReg = w_memtoreg_q;
  assign Exc        = exc_q;
  assign Exc_cause  = exc_cause_q;
  assign Exc_addr   = exc_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Directed self-checking bench for mem_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  logic        Clk;
  logic        Clrn;
  logic [31:0] M_Jtarg, M_Btarg, M_ALUout, M_busB;
  logic        M_Zero, M_Overflow;
  logic [4:0]  M_Rw;
  logic        M_Jump, M_Branch, M_MemWr, M_RegWr, M_MemtoReg;
  logic        NPC_sel, Flush, W_RegWr, W_MemtoReg, Exc;
  logic [31:0] NPC_target, W_Dout, W_ALUout, Exc_addr;
  logic [4:0]  W_Rw;
  logic [1:0]  Exc_cause;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage dut (
    .Clk(Clk), .Clrn(Clrn),
    .M_Jtarg(M_Jtarg), .M_Btarg(M_Btarg), .M_Zero(M_Zero), .M_Overflow(M_Overflow),
    .M_ALUout(M_ALUout), .M_busB(M_busB), .M_Rw(M_Rw),
    .M_Jump(M_Jump), .M_Branch(M_Branch), .M_MemWr(M_MemWr), .M_RegWr(M_RegWr),
    .M_MemtoReg(M_MemtoReg),
    .NPC_sel(NPC_sel), .NPC_target(NPC_target), .Flush(Flush),
    .W_Dout(W_Dout), .W_ALUout(W_ALUout), .W_Rw(W_Rw), .W_RegWr(W_RegWr),
    .W_MemtoReg(W_MemtoReg), .Exc(Exc), .Exc_cause(Exc_cause), .Exc_addr(Exc_addr)
  );

  initial Clk = 1'b1;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    M_Jtarg = 0; M_Btarg = 0; M_Zero = 0; M_Overflow = 0; M_ALUout = 0; M_busB = 0;
    M_Rw = 0; M_Jump = 0; M_Branch = 0; M_MemWr = 0; M_RegWr = 0; M_MemtoReg = 0;
  endtask

  // Advance past the next falling edge and settle.
  task automatic step();
    @(negedge Clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    idle(); M_MemWr = 1; M_ALUout = addr; M_busB = data;
    step();
  endtask

  task automatic load(input logic [31:0] addr, input logic [4:0] rw);
    idle(); M_MemtoReg = 1; M_RegWr = 1; M_ALUout = addr; M_Rw = rw;
    step();
  endtask

  task automatic pulse_reset();
    #2 Clrn = 1'b1;
    #1;
    check("rst_exc", {31'b0, Exc}, 0);
    check("rst_cause", {30'b0, Exc_cause}, 0);
    check("rst_addr", Exc_addr, 0);
    check("rst_dout", W_Dout, 0);
    check("rst_aluout", W_ALUout, 0);
    check("rst_regwr", {31'b0, W_RegWr}, 0);
    #1 Clrn = 1'b0;
  endtask

  initial begin
    idle();
    Clrn = 1'b1;
    step();
    check("init_dout", W_Dout, 0);
    check("init_rw", {27'b0, W_Rw}, 0);
    check("init_exc", {31'b0, Exc}, 0);
    check("init_cause", {30'b0, Exc_cause}, 0);
    #2 Clrn = 1'b0;

    // Store then load
    store(32'h10, 32'hDEADBEEF);
    check("st_aluout", W_ALUout, 32'h10);
    check("st_regwr", {31'b0, W_RegWr}, 0);
    load(32'h10, 5'd5);
    check("ld_dout", W_Dout, 32'hDEADBEEF);
    check("ld_rw", {27'b0, W_Rw}, 5);
    check("ld_regwr", {31'b0, W_RegWr}, 1);
    check("ld_memtoreg", {31'b0, W_MemtoReg}, 1);

    // Read-before-write on the same edge
    store(32'h10, 32'h55555555);
    check("rbw_dout", W_Dout, 32'hDEADBEEF);
    load(32'h10, 5'd1);
    check("rbw_new", W_Dout, 32'h55555555);

    // Address wrap modulo 256 bytes
    store(32'h104, 32'h1234);
    load(32'h004, 5'd2);
    check("wrap_dout", W_Dout, 32'h1234);

    // Redirect priority
    idle(); M_Jump = 1; M_Branch = 1; M_Zero = 1; M_Jtarg = 32'h40; M_Btarg = 32'h80;
    #1;
    check("jmp_sel", {31'b0, NPC_sel}, 1);
    check("jmp_tgt", NPC_target, 32'h40);
    check("jmp_flush", {31'b0, Flush}, 1);
    M_Jump = 0;
    #1;
    check("br_tgt", NPC_target, 32'h80);
    check("br_sel", {31'b0, NPC_sel}, 1);
    M_Zero = 0;
    #1;
    check("nbr_sel", {31'b0, NPC_sel}, 0);
    check("nbr_tgt", NPC_target, 0);
    step();

    // Overflow halt
    store(32'h20, 32'h11111111);
    idle(); M_Overflow = 1; M_RegWr = 1; M_ALUout = 32'h7FFFFFFC; M_Jump = 1; M_Jtarg = 32'h99;
    #1;
    check("ovf_nosel", {31'b0, NPC_sel}, 0);
    step();
    check("ovf_regwr", {31'b0, W_RegWr}, 0);
    check("ovf_exc", {31'b0, Exc}, 1);
    check("ovf_cause", {30'b0, Exc_cause}, 1);
    check("ovf_addr", Exc_addr, 32'h7FFFFFFC);
    idle(); M_MemWr = 1; M_ALUout = 32'h20; M_busB = 32'hBADBAD00; M_Jump = 1; M_Jtarg = 32'h44;
    #1;
    check("halt_sel", {31'b0, NPC_sel}, 0);
    check("halt_flush", {31'b0, Flush}, 0);
    step();
    load(32'h20, 5'd3);
    check("halt_mem", W_Dout, 32'h11111111);
    check("halt_regwr", {31'b0, W_RegWr}, 0);
    check("halt_addr", Exc_addr, 32'h7FFFFFFC);
    check("halt_cause", {30'b0, Exc_cause}, 1);

    // Asynchronous reset in HALT
    pulse_reset();

    // Misaligned load
    idle(); M_MemtoReg = 1; M_ALUout = 32'h13;
    step();
    check("mis_exc", {31'b0, Exc}, 1);
    check("mis_cause", {30'b0, Exc_cause}, 2);
    check("mis_addr", Exc_addr, 32'h13);
    pulse_reset();

    // Overflow plus misaligned store: overflow wins, no write
    idle(); M_MemWr = 1; M_Overflow = 1; M_ALUout = 32'h22; M_busB = 32'hFFFFFFFF;
    step();
    check("both_cause", {30'b0, Exc_cause}, 1);
    pulse_reset();
    load(32'h20, 5'd4);
    check("both_nowr", W_Dout, 32'h11111111);

    // Store after release
    store(32'h24, 32'hCAFE);
    load(32'h24, 5'd6);
    check("post_dout", W_Dout, 32'hCAFE);
    check("post_exc", {31'b0, Exc}, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have these ports, clock and reset first (name  direction  width  meaning):
- Clk  in  1  single clock; all state updates on falling edge.
- Clrn  in  1  asynchronous, active-high reset.
- M_Jtarg  in  32  jump target.
- M_Btarg  in  32  branch target.
- M_Zero  in  1  ALU zero flag.
- M_Overflow  in  1  ALU overflow flag.
- M_ALUout  in  32  ALU result / memory byte address.
- M_busB  in  32  store data.
- M_Rw  in  5  destination register.
- M_Jump, M_Branch, M_MemWr, M_RegWr, M_MemtoReg  in  1 each  control bits.
- NPC_sel  out  1  1 = redirect PC to NPC_target.
- NPC_target  out  32  redirect address.
- Flush  out  1  squash younger IF/ID/EX contents.
- W_Dout  out  32  registered load data.
- W_ALUout  out  32  registered ALU result.
- W_Rw  out  5  registered destination.
- W_RegWr, W_MemtoReg  out  1 each  registered write-back controls.
- Exc  out  1  sticky exception flag.
- Exc_cause  out  2  01 overflow, 10 misaligned access.
- Exc_addr  out  32  M_ALUout of the faulting instruction.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high. The ports are named Clk and Clrn.

Function
REQ-003 The block SHALL contain a 64 x 32 data memory, word-indexed by M_ALUout[7:2]. Address bits [31:8] are ignored, so addresses wrap modulo 256 bytes.
REQ-004 Misaligned SHALL be asserted when (M_MemWr | M_MemtoReg) & (M_ALUout[1:0] != 0).
REQ-005 Fault SHALL be asserted when M_Overflow | Misaligned.
REQ-006 Halted SHALL equal Exc, the registered sticky flag.
REQ-007 The effective memory write SHALL be M_MemWr & ~Fault & ~Halted. When it is asserted, mem[M_ALUout[7:2]] takes M_busB on the falling edge of Clk.
REQ-008 Memory read SHALL be combinational from the word index. The MEM/WB capture at an edge SHALL see the data as it was before any write on that same edge.
REQ-009 On each falling edge, with Clrn low, the MEM/WB register SHALL load:
- W_Dout from the read data;
- W_ALUout from M_ALUout;
- W_Rw from M_Rw;
- W_MemtoReg from M_MemtoReg;
- W_RegWr from M_RegWr & ~Fault & ~Halted.
REQ-010 W_* outputs SHALL have exactly one falling-edge latency from the M_* inputs.
REQ-011 Redirect SHALL be combinational, in the same cycle as the inputs, and gated by ~Fault & ~Halted:
- M_Jump = 1: NPC_sel = 1, NPC_target = M_Jtarg.
- else M_Branch & M_Zero: NPC_sel = 1, NPC_target = M_Btarg.
- else NPC_sel = 0, NPC_target = 0.
REQ-012 M_Jump SHALL take priority over M_Branch when both are asserted.
REQ-013 Flush SHALL equal NPC_sel.
REQ-014 Exception state machine, states RUN and HALT:
- RUN -> HALT on a falling edge where Fault = 1.
- In that transition: Exc <= 1, Exc_cause <= {Misaligned & ~M_Overflow, M_Overflow}, Exc_addr <= M_ALUout.
- HALT is left only by reset.
- In HALT, Exc_cause and Exc_addr hold their values; memory writes, W_RegWr and redirects stay suppressed.
REQ-015 When overflow and misalignment occur together, Exc_cause SHALL be 01 (overflow wins).
REQ-016 Memory contents SHALL be initialised to zero at time zero and SHALL NOT be cleared by Clrn.

Reset
REQ-017 While Clrn is high, all W_* outputs, Exc, Exc_cause and Exc_addr SHALL be 0, and the state SHALL be RUN. This takes effect immediately, without waiting for a clock edge.
REQ-018 Memory writes SHALL be suppressed while Clrn is high.
REQ-019 Reset SHALL take effect mid-cycle, overriding any fault or write on the same edge.
REQ-020 Release of Clrn SHALL resume normal operation at the next falling edge.

Verification
REQ-021 Store then load:
- Stimulus: MemWr with ALUout=0x10, busB=0xDEADBEEF; next cycle MemtoReg=1, RegWr=1, ALUout=0x10, Rw=5.
- Required response: after the second falling edge, W_Dout=0xDEADBEEF, W_Rw=5, W_RegWr=1.
REQ-022 Address wrap:
- Stimulus: store 0x1234 at ALUout=0x104, then load from 0x004.
- Required response: W_Dout=0x1234.
REQ-023 Branch/jump priority:
- Stimulus: Jump=1, Branch=1, Zero=1, Jtarg=0x40, Btarg=0x80.
- Required response: NPC_sel=1, NPC_target=0x40, Flush=1.
- Stimulus: Jump=0 with the same branch inputs.
- Required response: NPC_target=0x80.
REQ-024 Overflow halt:
- Stimulus: Overflow=1, RegWr=1, ALUout=0x7FFFFFFC.
- Required response: W_RegWr=0, Exc=1, Exc_cause=01, Exc_addr=0x7FFFFFFC.
- Stimulus: a later store to 0x20.
- Required response: memory unchanged, NPC_sel stays 0.
REQ-025 Misaligned load:
- Stimulus: ALUout=0x13, MemtoReg=1.
- Required response: Exc_cause=10, Exc_addr=0x13.
REQ-026 Asynchronous reset in HALT:
- Stimulus: raise Clrn between edges while in HALT.
- Required response: Exc, Exc_cause, Exc_addr and W_* go to 0 immediately.
- Required response after release: the next store succeeds.
